// File: rtl/elevator_scheduler.sv
// Elevator car scheduler: latches per-floor calls, chooses a travel direction,
// requests motor steps and door cycles, and tracks the current floor.
module elevator_scheduler #(
  parameter int NUM_FLOORS  = 4,
  parameter int START_FLOOR = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] CallReq,
  input  logic       Step,
  input  logic       DoorDone,
  output logic       Moving,
  output logic       Dir,
  output logic [1:0] Floor,
  output logic [3:0] Pending,
  output logic       DoorReq
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MOVE    = 2'd1;
  localparam logic [1:0] S_EVAL    = 2'd2;
  localparam logic [1:0] S_SERVICE = 2'd3;

  localparam logic [1:0] TOP_FLOOR   = 2'(NUM_FLOORS - 1);
  localparam logic [1:0] RESET_FLOOR = 2'(START_FLOOR);

  logic [1:0] state_reg, state_next;
  logic [1:0] floor_reg, floor_next;
  logic       dir_reg, dir_next;
  logic [3:0] pending_reg, pending_next;
  logic       moving_reg, door_req_reg;

  logic [3:0] floor_valid;
  logic [3:0] above_mask;
  logic [3:0] below_mask;
  logic [3:0] here_mask;
  logic [3:0] call_valid;
  logic       pend_above, pend_below, pend_here;
  logic       pend_ahead, pend_behind;
  logic [1:0] decide_state;
  logic       decide_flip;
  logic       clear_here;

  // Per-floor masks relative to the car position; floors past NUM_FLOORS never
  // latch a call.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_floor
      assign floor_valid[gi] = (gi < NUM_FLOORS);
      assign above_mask[gi]  = (2'(gi) > floor_reg);
      assign below_mask[gi]  = (2'(gi) < floor_reg);
      assign here_mask[gi]   = (2'(gi) == floor_reg);
    end
  endgenerate

  assign call_valid  = CallReq & floor_valid;
  assign pend_above  = |(pending_reg & above_mask);
  assign pend_below  = |(pending_reg & below_mask);
  assign pend_here   = |(pending_reg & here_mask);
  assign pend_ahead  = dir_reg ? pend_above : pend_below;
  assign pend_behind = dir_reg ? pend_below : pend_above;

  // Scheduling decision used by IDLE and EVAL: serve here, keep going, or reverse.
  always_comb begin
    decide_state = S_IDLE;
    decide_flip  = 1'b0;
    if (pend_here) begin
      decide_state = S_SERVICE;
    end else if (pend_ahead) begin
      decide_state = S_MOVE;
    end else if (pend_behind) begin
      decide_state = S_MOVE;
      decide_flip  = 1'b1;
    end
  end

  // Next state, floor and direction; Step and DoorDone only matter in their own states.
  always_comb begin
    state_next = state_reg;
    floor_next = floor_reg;
    dir_next   = dir_reg;
    case (state_reg)
      S_IDLE, S_EVAL: begin
        state_next = decide_state;
        if (decide_flip) begin
          dir_next = ~dir_reg;
        end
      end
      S_MOVE: begin
        if (Step) begin
          state_next = S_EVAL;
          // Saturate at the end floors; the step still completes the move.
          if (dir_reg && (floor_reg != TOP_FLOOR)) begin
            floor_next = floor_reg + 2'd1;
          end else if (!dir_reg && (floor_reg != 2'd0)) begin
            floor_next = floor_reg - 2'd1;
          end
        end
      end
      S_SERVICE: begin
        if (DoorDone) begin
          state_next = S_EVAL;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Call lamps: new calls latch, the current floor clears on entry to and
  // during service, and both can happen on the same edge.
  always_comb begin
    clear_here   = (state_reg == S_SERVICE) || (state_next == S_SERVICE);
    pending_next = (pending_reg | call_valid) & floor_valid;
    if (clear_here) begin
      pending_next = pending_next & ~here_mask;
    end
  end

  // State and output registers; reset overrides every other input.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= S_IDLE;
      floor_reg    <= RESET_FLOOR;
      dir_reg      <= 1'b1;
      pending_reg  <= 4'b0000;
      moving_reg   <= 1'b0;
      door_req_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      floor_reg    <= floor_next;
      dir_reg      <= dir_next;
      pending_reg  <= pending_next;
      moving_reg   <= (state_next == S_MOVE);
      door_req_reg <= (state_next == S_SERVICE);
    end
  end

  assign Moving  = moving_reg;
  assign Dir     = dir_reg;
  assign Floor   = floor_reg;
  assign Pending = pending_reg;
  assign DoorReq = door_req_reg;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler: a vector table for the main flow plus
// hand-written sequences for reversal, saturation and mid-move reset.
module tb_elevator_scheduler;

  logic       CLK;
  logic       RST;
  logic [3:0] CallReq;
  logic       Step;
  logic       DoorDone;
  logic       Moving;
  logic       Dir;
  logic [1:0] Floor;
  logic [3:0] Pending;
  logic       DoorReq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic [3:0] call;
    logic       step;
    logic       done;
    logic       mov;
    logic       dir;
    logic [1:0] flr;
    logic [3:0] pend;
    logic       door;
  } vec_t;

  vec_t tbl[$];

  elevator_scheduler #(.NUM_FLOORS(4), .START_FLOOR(0)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .CallReq (CallReq),
    .Step    (Step),
    .DoorDone(DoorDone),
    .Moving  (Moving),
    .Dir     (Dir),
    .Floor   (Floor),
    .Pending (Pending),
    .DoorReq (DoorReq)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // in: {rst, call[3:0], step, done}   exp: {moving, dir, floor[1:0], pending[3:0], doorreq}
  task automatic add(input logic [6:0] in_bits, input logic [8:0] exp_bits);
    vec_t v;
    v.rst  = in_bits[6];
    v.call = in_bits[5:2];
    v.step = in_bits[1];
    v.done = in_bits[0];
    v.mov  = exp_bits[8];
    v.dir  = exp_bits[7];
    v.flr  = exp_bits[6:5];
    v.pend = exp_bits[4:1];
    v.door = exp_bits[0];
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One clock: drive inputs after a falling edge, sample after the next one.
  task automatic cyc(input logic [3:0] c, input logic s, input logic d, input logic r);
    RST      = r;
    CallReq  = c;
    Step     = s;
    DoorDone = d;
    @(posedge CLK);
    @(negedge CLK);
    $display("cycle: rst=%b call=%b step=%b done=%b -> mov=%b dir=%b floor=%0d pend=%b door=%b",
             r, c, s, d, Moving, Dir, Floor, Pending, DoorReq);
  endtask

  task automatic nop();
    cyc(4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic stp();
    cyc(4'b0000, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic dd();
    cyc(4'b0000, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    RST      = 1'b1;
    CallReq  = 4'b0000;
    Step     = 1'b0;
    DoorDone = 1'b0;

    // Reset, call floor 2, travel two steps, service, held call absorbed
    add(7'b1_0000_0_0, 9'b0_1_00_0000_0);
    add(7'b0_0100_0_0, 9'b0_1_00_0100_0);
    add(7'b0_0000_0_0, 9'b1_1_00_0100_0);
    add(7'b0_0000_0_0, 9'b1_1_00_0100_0);
    add(7'b0_0000_1_0, 9'b0_1_01_0100_0);
    add(7'b0_0000_0_0, 9'b1_1_01_0100_0);
    add(7'b0_0000_1_0, 9'b0_1_10_0100_0);
    add(7'b0_0000_0_0, 9'b0_1_10_0000_1);
    add(7'b0_0100_0_0, 9'b0_1_10_0000_1);
    add(7'b0_0100_0_1, 9'b0_1_10_0000_0);
    add(7'b0_0000_0_0, 9'b0_1_10_0000_0);
    // Step and DoorDone while idle are ignored
    add(7'b0_0000_1_1, 9'b0_1_10_0000_0);
    // Call at the current floor while idle goes straight to service
    add(7'b0_0100_0_0, 9'b0_1_10_0100_0);
    add(7'b0_0000_0_0, 9'b0_1_10_0000_1);
    add(7'b0_0000_0_1, 9'b0_1_10_0000_0);
    add(7'b0_0000_0_0, 9'b0_1_10_0000_0);
    // New call elsewhere on the same edge the current floor clears
    add(7'b0_0100_0_0, 9'b0_1_10_0100_0);
    add(7'b0_1000_0_0, 9'b0_1_10_1000_1);
    add(7'b0_0000_0_1, 9'b0_1_10_1000_0);
    add(7'b0_0000_0_0, 9'b1_1_10_1000_0);
    add(7'b0_0000_1_0, 9'b0_1_11_1000_0);
    add(7'b0_0000_0_0, 9'b0_1_11_0000_1);
    add(7'b0_0000_0_1, 9'b0_1_11_0000_0);
    add(7'b0_0000_0_0, 9'b0_1_11_0000_0);
    // Call behind the car: reverse and descend to floor 0
    add(7'b0_0001_0_0, 9'b0_1_11_0001_0);
    add(7'b0_0000_0_0, 9'b1_0_11_0001_0);
    add(7'b0_0000_1_0, 9'b0_0_10_0001_0);
    add(7'b0_0000_0_0, 9'b1_0_10_0001_0);
    add(7'b0_0000_1_0, 9'b0_0_01_0001_0);
    add(7'b0_0000_0_0, 9'b1_0_01_0001_0);
    add(7'b0_0000_1_0, 9'b0_0_00_0001_0);
    add(7'b0_0000_0_0, 9'b0_0_00_0000_1);
    add(7'b0_0000_0_1, 9'b0_0_00_0000_0);
    add(7'b0_0000_0_0, 9'b0_0_00_0000_0);
    // Reverse upward, then reset in the middle of service
    add(7'b0_0100_0_0, 9'b0_0_00_0100_0);
    add(7'b0_0000_0_0, 9'b1_1_00_0100_0);
    add(7'b0_0000_1_0, 9'b0_1_01_0100_0);
    add(7'b0_0000_0_0, 9'b1_1_01_0100_0);
    add(7'b0_0000_1_0, 9'b0_1_10_0100_0);
    add(7'b0_0000_0_0, 9'b0_1_10_0000_1);
    add(7'b1_0010_0_1, 9'b0_1_00_0000_0);
    // First cycle after reset samples calls; reset again mid-move with Step
    add(7'b0_0010_0_0, 9'b0_1_00_0010_0);
    add(7'b0_0000_0_0, 9'b1_1_00_0010_0);
    add(7'b1_1000_1_0, 9'b0_1_00_0000_0);
    add(7'b0_0000_0_0, 9'b0_1_00_0000_0);

    @(negedge CLK);
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].call, tbl[i].step, tbl[i].done, tbl[i].rst);
      chk($sformatf("v%0d moving", i),  8'(Moving),  8'(tbl[i].mov));
      chk($sformatf("v%0d dir", i),     8'(Dir),     8'(tbl[i].dir));
      chk($sformatf("v%0d floor", i),   8'(Floor),   8'(tbl[i].flr));
      chk($sformatf("v%0d pending", i), 8'(Pending), 8'(tbl[i].pend));
      chk($sformatf("v%0d doorreq", i), 8'(DoorReq), 8'(tbl[i].door));
    end

    // Car at 1 heading up with calls at 3 and 0: finish upward first, then reverse
    cyc(4'b0010, 1'b0, 1'b0, 1'b0);
    nop();
    stp();
    nop();
    chk("sq1 service1 door", 8'(DoorReq), 8'd1);
    cyc(4'b1001, 1'b0, 1'b0, 1'b0);
    chk("sq1 pend1001", 8'(Pending), 8'b1001);
    dd();
    nop();
    chk("sq1 up moving", 8'(Moving), 8'd1);
    chk("sq1 up dir", 8'(Dir), 8'd1);
    stp();
    nop();
    stp();
    nop();
    chk("sq1 floor3", 8'(Floor), 8'd3);
    chk("sq1 floor3 door", 8'(DoorReq), 8'd1);
    chk("sq1 pend0001", 8'(Pending), 8'b0001);
    dd();
    nop();
    chk("sq1 rev dir", 8'(Dir), 8'd0);
    chk("sq1 rev moving", 8'(Moving), 8'd1);
    stp();
    nop();
    stp();
    nop();
    stp();
    nop();
    chk("sq1 floor0", 8'(Floor), 8'd0);
    chk("sq1 floor0 door", 8'(DoorReq), 8'd1);
    chk("sq1 pend0", 8'(Pending), 8'b0000);
    dd();
    nop();

    // Top-floor saturation: climb to 3, Step while idle, then a Step in MOVE at the limit
    cyc(4'b1000, 1'b0, 1'b0, 1'b0);
    nop();
    chk("sq2 flip up dir", 8'(Dir), 8'd1);
    stp();
    nop();
    stp();
    nop();
    stp();
    nop();
    dd();
    nop();
    stp();
    chk("sq2 idle step floor", 8'(Floor), 8'd3);
    chk("sq2 idle step moving", 8'(Moving), 8'd0);
    force dut.state_reg = 2'd1;
    stp();
    chk("sq2 saturate floor", 8'(Floor), 8'd3);
    chk("sq2 saturate moving", 8'(Moving), 8'd0);
    release dut.state_reg;
    cyc(4'b0000, 1'b0, 1'b0, 1'b1);
    chk("sq2 reset floor", 8'(Floor), 8'd0);

    // Reset while moving down at floor 2 with calls at 1 and 0
    cyc(4'b1000, 1'b0, 1'b0, 1'b0);
    nop();
    stp();
    nop();
    stp();
    nop();
    stp();
    nop();
    cyc(4'b0011, 1'b0, 1'b0, 1'b0);
    dd();
    nop();
    stp();
    nop();
    chk("sq3 pre floor", 8'(Floor), 8'd2);
    chk("sq3 pre pend", 8'(Pending), 8'b0011);
    chk("sq3 pre moving", 8'(Moving), 8'd1);
    chk("sq3 pre dir", 8'(Dir), 8'd0);
    cyc(4'b0100, 1'b1, 1'b0, 1'b1);
    chk("sq3 rst floor", 8'(Floor), 8'd0);
    chk("sq3 rst pend", 8'(Pending), 8'b0000);
    chk("sq3 rst moving", 8'(Moving), 8'd0);
    chk("sq3 rst dir", 8'(Dir), 8'd1);
    chk("sq3 rst door", 8'(DoorReq), 8'd0);
    nop();
    chk("sq3 idle moving", 8'(Moving), 8'd0);
    chk("sq3 idle door", 8'(DoorReq), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/elevator_scheduler.md
ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

Interface
REQ-001 Parameter NUM_FLOORS, default 4, number of served floors; legal range 2..4.
REQ-002 Parameter START_FLOOR, default 0, floor index loaded at reset; SHALL be < NUM_FLOORS.
REQ-003 CLK  input  1  system clock; all state updates on rising edge; one clock domain.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 CallReq  input  4  per-floor call buttons, level-sampled every cycle; bits >= NUM_FLOORS ignored.
REQ-006 Step  input  1  one-cycle pulse from motor sequencer: car has moved one floor in direction Dir.
REQ-007 DoorDone  input  1  one-cycle pulse from door sequencer: open/dwell/close cycle at current floor complete.
REQ-008 Moving  output  1  registered; request to motor sequencer to travel in direction Dir.
REQ-009 Dir  output  1  registered; 1 = up (increasing floor), 0 = down.
REQ-010 Floor  output  2  registered; current car floor index.
REQ-011 Pending  output  4  registered; outstanding call per floor (call lamps).
REQ-012 DoorReq  output  1  registered; request to door sequencer to service current floor.

Function
REQ-013 States SHALL be IDLE, MOVE, EVAL, SERVICE; Moving=1 only in MOVE, DoorReq=1 only in SERVICE.
REQ-014 CallReq[i]=1 in cycle n SHALL set Pending[i] visible in cycle n+1; Pending[i] holds until serviced.
REQ-015 Entry into SERVICE SHALL clear Pending[Floor]; while in SERVICE, CallReq[Floor] SHALL be absorbed (Pending[Floor] stays 0).
REQ-016 Simultaneous set of Pending[j] (j != Floor) and clear of Pending[Floor] SHALL both take effect.
REQ-017 "Ahead" = any Pending bit strictly above Floor when Dir=1, strictly below when Dir=0; "behind" = opposite side.
REQ-018 IDLE and EVAL SHALL apply one decision each cycle, priority: Pending[Floor] -> SERVICE; else ahead -> MOVE; else behind -> toggle Dir, MOVE; else -> IDLE.
REQ-019 EVAL SHALL last exactly one cycle; IDLE SHALL persist until a decision other than IDLE results.
REQ-020 In MOVE, Step SHALL update Floor by +1 (Dir=1) or -1 (Dir=0) and transition to EVAL in the same edge; Moving drops to 0 one cycle after Step.
REQ-021 Floor SHALL saturate at 0 and NUM_FLOORS-1; Step at a limit SHALL leave Floor unchanged and still transition to EVAL.
REQ-022 Step outside MOVE SHALL be ignored (no Floor change, no state change).
REQ-023 In SERVICE, DoorDone SHALL transition to EVAL; DoorDone outside SERVICE SHALL be ignored.
REQ-024 Dir SHALL change only on the behind-reversal decision of REQ-018; never while in MOVE.
REQ-025 Latency: Pending call at idle car on adjacent floor -> Moving=1 on the cycle after Pending sets.
REQ-026 Unreachable state encodings SHALL recover to IDLE on the next edge with outputs per REQ-013.

Reset
REQ-027 RST=1 at a rising edge SHALL set state=IDLE, Floor=START_FLOOR, Dir=1, Pending=0, Moving=0, DoorReq=0.
REQ-028 RST SHALL take priority over CallReq, Step and DoorDone in the same cycle, including mid-MOVE and mid-SERVICE.
REQ-029 First cycle after RST deasserts SHALL sample CallReq normally.

Verification
REQ-030 Reset, Floor=0, pulse CallReq=4'b0100 one cycle -> Pending=0100 next cycle, Moving=1 Dir=1 the cycle after; two Step pulses -> Floor=2, SERVICE, DoorReq=1, Pending=0000.
REQ-031 Car at floor 2 in SERVICE, CallReq[2]=1 held -> Pending[2] stays 0; DoorDone -> EVAL -> IDLE, Moving=0 DoorReq=0.
REQ-032 Car at 1, Dir=1, Pending=1001 -> moves up first (Dir=1) to floor 3, services, then reverses Dir=0 and travels to floor 0.
REQ-033 Car at 3 in MOVE with Dir=1 forced, Step pulse -> Floor stays 3, EVAL entered; Step in IDLE -> no change.
REQ-034 RST asserted in MOVE with Floor=2, Pending=0011 -> next cycle Floor=START_FLOOR, Pending=0000, Moving=0, state IDLE.
REQ-035 CallReq at Floor while IDLE -> SERVICE directly (no Moving pulse), DoorReq=1 one cycle after Pending sets.
